// File: rtl/sprite_row_fetcher_if.sv
// Pixel stream between the sprite row fetcher and the scanline compositor.
//   pixel_valid       - pixel_data/col/last/transparent hold a pixel
//   pixel_ready       - consumer accepts the pixel this cycle
//   pixel_data        - 24-bit RGB
//   pixel_transparent - pixel_data equals the transparent key
//   pixel_col         - sprite column the pixel came from
//   pixel_last        - final pixel of the requested run
interface sprite_row_fetcher_if;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [23:0] pixel_data;
    logic        pixel_transparent;
    logic [6:0]  pixel_col;
    logic        pixel_last;

    modport master (
        output pixel_valid, pixel_data, pixel_transparent, pixel_col, pixel_last,
        input  pixel_ready
    );
    modport slave (
        input  pixel_valid, pixel_data, pixel_transparent, pixel_col, pixel_last,
        output pixel_ready
    );
endinterface

// File: rtl/sprite_row_fetcher.sv
// Sprite row fetcher: reads one clipped row segment of a sprite ROM and
// streams it out as pixels with valid/ready flow control.
// Ports:
//   Clk, Reset           - clock, synchronous active-high reset
//   start                - request strobe, accepted only in IDLE outside the done cycle
//   sprite_sel/row/col_start/run_len - request (0 brick, 1 question, 2 bcloud, 3 bhill)
//   busy, done           - run in progress / one-cycle completion pulse
//   rom_addr, rom_sel    - shared ROM read address and latched sprite select
//   *_data               - ROM read data, valid one cycle after rom_addr
//   pix                  - pixel stream (master side)
// Pipeline: address stage -> ROM data stage -> output register + 2-entry skid.
module sprite_row_fetcher #(
    parameter logic [23:0] TRANSPARENT_KEY = 24'hFF00FF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [1:0]  sprite_sel,
    input  logic [5:0]  row,
    input  logic [6:0]  col_start,
    input  logic [6:0]  run_len,
    output logic        busy,
    output logic        done,
    output logic [11:0] rom_addr,
    output logic [1:0]  rom_sel,
    input  logic [23:0] brick_data,
    input  logic [23:0] question_data,
    input  logic [23:0] bcloud_data,
    input  logic [23:0] bhill_data,
    sprite_row_fetcher_if.master pix
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

    typedef struct packed {
        logic [23:0] data;
        logic        transp;
        logic [6:0]  col;
        logic        last;
    } pix_t;

    state_e      state_q, state_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [11:0] rom_addr_q, rom_addr_d, base_q, base_d;
    logic [1:0]  sel_q, sel_d;
    logic [6:0]  icol_q, icol_d, rem_q, rem_d;
    logic        a_vld_q, a_vld_d, a_last_q, a_last_d;
    logic [6:0]  a_col_q, a_col_d;
    logic        d_vld_q, d_vld_d, d_last_q, d_last_d;
    logic [6:0]  d_col_q, d_col_d;
    logic        out_vld_q, out_vld_d;
    pix_t        out_q, out_d, d_word;
    pix_t [1:0]  sk_q, sk_d;
    logic [1:0]  sk_cnt_q, sk_cnt_d;

    logic [6:0]  g_w, g_avail, g_n;
    logic [5:0]  g_h;
    logic [11:0] g_base;
    logic [23:0] rom_word;
    logic [2:0]  occ;
    logic        pop, issue_ok;

    // Geometry of the requested sprite; row*W built from shifts.
    always_comb begin
        g_w    = 7'd80;
        g_h    = 6'd35;
        g_base = {row, 6'b0} + {2'b0, row, 4'b0};
        case (sprite_sel)
            2'd0, 2'd1: begin
                g_w    = 7'd16;
                g_h    = 6'd16;
                g_base = {2'b0, row, 4'b0};
            end
            2'd2: begin
                g_w    = 7'd48;
                g_h    = 6'd32;
                g_base = {1'b0, row, 5'b0} + {2'b0, row, 4'b0};
            end
            default: ;
        endcase
        g_avail = g_w - col_start;
        if (row >= g_h || col_start >= g_w) g_n = '0;
        else if (run_len < g_avail)         g_n = run_len;
        else                                g_n = g_avail;
    end

    always_comb begin
        case (sel_q)
            2'd0:    rom_word = brick_data;
            2'd1:    rom_word = question_data;
            2'd2:    rom_word = bcloud_data;
            default: rom_word = bhill_data;
        endcase
        d_word.data   = rom_word;
        d_word.transp = (rom_word == TRANSPARENT_KEY);
        d_word.col    = d_col_q;
        d_word.last   = d_last_q;
    end

    // Output register fed from the skid head first, so order is preserved.
    always_comb begin
        pop       = out_vld_q && pix.pixel_ready;
        out_vld_d = out_vld_q;
        out_d     = out_q;
        sk_d      = sk_q;
        sk_cnt_d  = sk_cnt_q;
        if (pop || !out_vld_q) begin
            if (sk_cnt_q != 2'd0) begin
                out_d     = sk_q[0];
                out_vld_d = 1'b1;
                sk_d[0]   = sk_q[1];
                sk_cnt_d  = sk_cnt_q - 2'd1;
                if (d_vld_q) begin
                    if (sk_cnt_q == 2'd1) sk_d[0] = d_word;
                    else                  sk_d[1] = d_word;
                    sk_cnt_d = sk_cnt_q;
                end
            end else if (d_vld_q) begin
                out_d     = d_word;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (d_vld_q) begin
            if (sk_cnt_q == 2'd0) sk_d[0] = d_word;
            else                  sk_d[1] = d_word;
            sk_cnt_d = sk_cnt_q + 2'd1;
        end
        // A new address lands two edges later; with no pops meanwhile the
        // stored words plus the one in the address stage plus the new one
        // must fit in output + skid (3 words).
        occ      = {2'b0, out_vld_d} + {1'b0, sk_cnt_d} + {2'b0, a_vld_q};
        issue_ok = (occ <= 3'd2);
    end

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rom_addr_d = rom_addr_q;
        base_d     = base_q;
        sel_d      = sel_q;
        icol_d     = icol_q;
        rem_d      = rem_q;
        a_vld_d    = 1'b0;
        a_col_d    = a_col_q;
        a_last_d   = a_last_q;
        d_vld_d    = a_vld_q;
        d_col_d    = a_col_q;
        d_last_d   = a_last_q;
        case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    sel_d = sprite_sel;
                    if (g_n == 7'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = FETCH;
                        busy_d     = 1'b1;
                        base_d     = g_base;
                        rom_addr_d = g_base + {5'b0, col_start};
                        a_vld_d    = 1'b1;
                        a_col_d    = col_start;
                        a_last_d   = (g_n == 7'd1);
                        icol_d     = col_start + 7'd1;
                        rem_d      = g_n - 7'd1;
                    end
                end
            end
            FETCH: begin
                if (rem_q == 7'd0) begin
                    state_d = DRAIN;
                end else if (issue_ok) begin
                    rom_addr_d = base_q + {5'b0, icol_q};
                    a_vld_d    = 1'b1;
                    a_col_d    = icol_q;
                    a_last_d   = (rem_q == 7'd1);
                    icol_d     = icol_q + 7'd1;
                    rem_d      = rem_q - 7'd1;
                end
            end
            default: ;
        endcase
        // Run ends on the handshake of the pixel tagged last.
        if (pop && out_q.last) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rom_addr_q <= '0;
            base_q     <= '0;
            sel_q      <= '0;
            icol_q     <= '0;
            rem_q      <= '0;
            a_vld_q    <= 1'b0;
            a_col_q    <= '0;
            a_last_q   <= 1'b0;
            d_vld_q    <= 1'b0;
            d_col_q    <= '0;
            d_last_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            out_q      <= '0;
            sk_q       <= '0;
            sk_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rom_addr_q <= rom_addr_d;
            base_q     <= base_d;
            sel_q      <= sel_d;
            icol_q     <= icol_d;
            rem_q      <= rem_d;
            a_vld_q    <= a_vld_d;
            a_col_q    <= a_col_d;
            a_last_q   <= a_last_d;
            d_vld_q    <= d_vld_d;
            d_col_q    <= d_col_d;
            d_last_q   <= d_last_d;
            out_vld_q  <= out_vld_d;
            out_q      <= out_d;
            sk_q       <= sk_d;
            sk_cnt_q   <= sk_cnt_d;
        end
    end

    assign busy                  = busy_q;
    assign done                  = done_q;
    assign rom_addr              = rom_addr_q;
    assign rom_sel               = sel_q;
    assign pix.pixel_valid       = out_vld_q;
    assign pix.pixel_data        = out_q.data;
    assign pix.pixel_transparent = out_q.transp;
    assign pix.pixel_col         = out_q.col;
    assign pix.pixel_last        = out_q.last;
endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Bench for sprite_row_fetcher: ROM models, a request table with hand-derived
// clip counts and first addresses, a pixel scoreboard, and hand sequences for
// reset mid-run and start during busy/done.
module tb_sprite_row_fetcher;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  sprite_sel = '0;
    logic [5:0]  row = '0;
    logic [6:0]  col_start = '0;
    logic [6:0]  run_len = '0;
    logic        busy, done;
    logic [11:0] rom_addr;
    logic [1:0]  rom_sel;
    logic [23:0] brick_data, question_data, bcloud_data, bhill_data;

    sprite_row_fetcher_if pif();

    sprite_row_fetcher dut (
        .Clk(Clk), .Reset(Reset), .start(start), .sprite_sel(sprite_sel),
        .row(row), .col_start(col_start), .run_len(run_len),
        .busy(busy), .done(done), .rom_addr(rom_addr), .rom_sel(rom_sel),
        .brick_data(brick_data), .question_data(question_data),
        .bcloud_data(bcloud_data), .bhill_data(bhill_data), .pix(pif)
    );

    always #5 Clk = ~Clk;

    // ROM contents: a tagged pattern, with one transparent brick word at 53.
    function automatic logic [23:0] rom_fn(input logic [1:0] s, input logic [11:0] a);
        if (s == 2'd0 && a == 12'd53) return 24'hFF00FF;
        return {6'h15, s, 4'h0, a};
    endfunction

    always @(posedge Clk) begin
        brick_data    <= rom_fn(2'd0, {4'b0, rom_addr[7:0]});
        question_data <= rom_fn(2'd1, {4'b0, rom_addr[7:0]});
        bcloud_data   <= rom_fn(2'd2, {1'b0, rom_addr[10:0]});
        bhill_data    <= rom_fn(2'd3, rom_addr);
    end

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [23:0] data;
        logic [6:0]  col;
        logic        last;
        logic        transp;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [1:0] sel;
        logic [5:0] row;
        logic [6:0] col;
        logic [6:0] len;
        int         mode;   // 0 ready always, 1 random ready, 2 scripted stall
        int         n;      // expected clipped pixel count
        int         addr0;  // expected first ROM address
    } vec_t;
    vec_t vecs[10];

    int rdy_mode = 0;
    int hs_cnt = 0;
    int rphase = 0;
    int rcnt = 0;
    int first_vld_cyc = -1;

    // Consumer ready driver.
    initial begin
        pif.pixel_ready = 1'b1;
        forever begin
            @(posedge Clk); #1;
            case (rdy_mode)
                0: pif.pixel_ready = 1'b1;
                1: pif.pixel_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (rphase == 0) begin
                        if (hs_cnt >= 3) begin
                            rphase = 1; rcnt = 1; pif.pixel_ready = 1'b0;
                        end else pif.pixel_ready = 1'b1;
                    end else if (rphase == 1) begin
                        if (rcnt < 5) begin
                            rcnt++; pif.pixel_ready = 1'b0;
                        end else begin
                            rphase = 2; pif.pixel_ready = 1'b1;
                        end
                    end else pif.pixel_ready = !pif.pixel_ready;
                end
            endcase
        end
    end

    // Pixel monitor: scoreboard compare on handshake, hold check during stall.
    initial begin
        logic        prev_stall;
        logic [23:0] p_data;
        logic [6:0]  p_col;
        logic        p_last, p_tr;
        exp_t        e;
        prev_stall = 1'b0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", int'(pif.pixel_valid), 1);
                    chk("hold_data",  int'(pif.pixel_data), int'(p_data));
                    chk("hold_col",   int'(pif.pixel_col), int'(p_col));
                    chk("hold_last",  int'(pif.pixel_last), int'(p_last));
                    chk("hold_transp", int'(pif.pixel_transparent), int'(p_tr));
                end
                if (pif.pixel_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
                if (pif.pixel_valid && pif.pixel_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pixel", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pix_data",   int'(pif.pixel_data), int'(e.data));
                        chk("pix_col",    int'(pif.pixel_col), int'(e.col));
                        chk("pix_last",   int'(pif.pixel_last), int'(e.last));
                        chk("pix_transp", int'(pif.pixel_transparent), int'(e.transp));
                    end
                    hs_cnt++;
                end
                prev_stall = pif.pixel_valid && !pif.pixel_ready;
                p_data = pif.pixel_data; p_col = pif.pixel_col;
                p_last = pif.pixel_last; p_tr = pif.pixel_transparent;
            end
        end
    end

    task automatic push_exp(input vec_t v);
        exp_t e;
        int   a;
        for (int i = 0; i < v.n; i++) begin
            a        = v.addr0 + i;
            e.data   = rom_fn(v.sel, 12'(a));
            e.col    = 7'(v.col + i);
            e.last   = (i == v.n - 1);
            e.transp = (v.sel == 2'd0 && a == 53);
            exp_q.push_back(e);
        end
    endtask

    // Drives one request in cycle 0 and follows it until done.
    task automatic run_vec(input vec_t v);
        int          dcyc, cyc0;
        logic [11:0] addr_prev;
        @(posedge Clk); #1;
        cyc0 = cyc;
        addr_prev = rom_addr;
        hs_cnt = 0; rphase = 0; rcnt = 0; first_vld_cyc = -1;
        rdy_mode = v.mode;
        sprite_sel = v.sel; row = v.row; col_start = v.col; run_len = v.len;
        start = 1'b1;
        push_exp(v);
        dcyc = -1;
        for (int k = 1; k <= 600 && dcyc < 0; k++) begin
            @(posedge Clk); #1;
            start = 1'b0;
            @(negedge Clk);
            if (v.mode == 0 && v.n > 0) begin
                if (k <= v.n)     chk("rom_addr", int'(rom_addr), v.addr0 + k - 1);
                if (k <= v.n + 2) chk("busy_run", int'(busy), 1);
            end
            if (k == 1 && v.n > 0)  chk("rom_sel", int'(rom_sel), int'(v.sel));
            if (k == 1 && v.n == 0) chk("no_rom_access", int'(rom_addr), int'(addr_prev));
            if (done) dcyc = k;
        end
        if (dcyc < 0) chk("done_timeout", 0, 1);
        if (v.n == 0)         chk("done_cycle", dcyc, 1);
        else if (v.mode == 0) chk("done_cycle", dcyc, v.n + 3);
        chk("busy_at_done", int'(busy), 0);
        chk("sb_empty", exp_q.size(), 0);
        @(posedge Clk); @(negedge Clk);
        chk("done_pulse", int'(done), 0);
        if (v.n == 0)         chk("no_valid", first_vld_cyc, -1);
        else if (v.mode == 0) chk("first_valid", first_vld_cyc - cyc0, 3);
        exp_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  int'(busy), 0);
        chk({tag, "_done"},  int'(done), 0);
        chk({tag, "_addr"},  int'(rom_addr), 0);
        chk({tag, "_sel"},   int'(rom_sel), 0);
        chk({tag, "_valid"}, int'(pif.pixel_valid), 0);
        chk({tag, "_data"},  int'(pif.pixel_data), 0);
        chk({tag, "_col"},   int'(pif.pixel_col), 0);
        chk({tag, "_last"},  int'(pif.pixel_last), 0);
        chk({tag, "_transp"}, int'(pif.pixel_transparent), 0);
    endtask

    initial begin
        vecs[0] = '{2'd0, 6'd3,  7'd0,  7'd16,  0, 16, 48};
        vecs[1] = '{2'd3, 6'd34, 7'd70, 7'd20,  0, 10, 2790};
        vecs[2] = '{2'd2, 6'd32, 7'd0,  7'd5,   0, 0,  0};
        vecs[3] = '{2'd1, 6'd0,  7'd0,  7'd0,   0, 0,  0};
        vecs[4] = '{2'd1, 6'd15, 7'd2,  7'd12,  2, 12, 242};
        vecs[5] = '{2'd2, 6'd10, 7'd40, 7'd20,  1, 8,  520};
        vecs[6] = '{2'd0, 6'd3,  7'd5,  7'd1,   0, 1,  53};
        vecs[7] = '{2'd3, 6'd0,  7'd80, 7'd5,   0, 0,  0};
        vecs[8] = '{2'd1, 6'd16, 7'd0,  7'd4,   0, 0,  0};
        vecs[9] = '{2'd2, 6'd31, 7'd47, 7'd100, 1, 1,  1535};

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk_all_zero("reset");
        @(posedge Clk); #1;
        Reset = 1'b0;

        run_vec(vecs[0]);

        // Start ignored mid-run, then reset mid-run: no done, outputs cleared.
        @(posedge Clk); #1;
        rdy_mode = 0; first_vld_cyc = -1;
        sprite_sel = 2'd0; row = 6'd3; col_start = 7'd0; run_len = 7'd16;
        start = 1'b1;
        push_exp(vecs[0]);
        for (int k = 1; k <= 6; k++) begin
            @(posedge Clk); #1;
            start = (k == 5);
            if (k == 5) begin
                sprite_sel = 2'd2; row = 6'd0; col_start = 7'd0; run_len = 7'd5;
            end
            if (k == 6) Reset = 1'b1;
            @(negedge Clk);
            chk("midrun_done", int'(done), 0);
            if (k == 6) begin
                chk("ignored_start_addr", int'(rom_addr), 53);
                chk("ignored_start_sel",  int'(rom_sel), 0);
                chk("ignored_start_busy", int'(busy), 1);
            end
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        exp_q.delete();
        @(negedge Clk);
        chk_all_zero("midrun_reset");

        for (int i = 1; i < 10; i++) run_vec(vecs[i]);

        // Start held into the done cycle of a clipped request is ignored.
        @(posedge Clk); #1;
        rdy_mode = 0; first_vld_cyc = -1;
        sprite_sel = 2'd2; row = 6'd32; col_start = 7'd0; run_len = 7'd5;
        start = 1'b1;
        @(posedge Clk); #1;
        sprite_sel = 2'd0; row = 6'd0; col_start = 7'd0; run_len = 7'd4;
        @(negedge Clk);
        chk("zero_run_done", int'(done), 1);
        @(posedge Clk); #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            chk("done_cycle_start_busy", int'(busy), 0);
            chk("done_cycle_start_done", int'(done), 0);
            @(posedge Clk);
        end
        chk("done_cycle_start_valid", first_vld_cyc, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sprite_row_fetcher.md
Name: sprite_row_fetcher

Overview:
- Read-side initiator for the synchronous 24-bit sprite ROMs: brick, question, bcloud and bhill.
- On a request, it fetches one row segment of a selected sprite and returns it as a stream of pixels with a valid/ready handshake.
- It generates ROM addresses, absorbs the 1-cycle ROM read latency and clips requests to sprite bounds.
- It sits between the sprite ROMs and the scanline compositor, which consumes the pixel stream.

Parameters:
- TRANSPARENT_KEY, 24'hFF00FF, RGB value reported as transparent.
- Sprite geometry is fixed, not parameterised:
  - sel 0 = brick, 16x16
  - sel 1 = question, 16x16
  - sel 2 = bcloud, 48x32
  - sel 3 = bhill, 80x35

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- start  in  1  request strobe, sampled only while idle
- sprite_sel  in  2  sprite select (encoding above)
- row  in  6  sprite row
- col_start  in  7  first sprite column
- run_len  in  7  requested pixel count
- busy  out  1  request in progress
- done  out  1  one-cycle completion pulse
- rom_addr  out  12  shared ROM read address; brick/question use [7:0], bcloud uses [10:0]
- rom_sel  out  2  latched sprite_sel
- brick_data, question_data, bcloud_data, bhill_data  in  24 each  ROM data_Out, valid 1 cycle after address
- pixel_valid  out  1  pixel_data valid
- pixel_ready  in  1  consumer accepts the pixel
- pixel_data  out  24  RGB
- pixel_transparent  out  1  pixel_data == TRANSPARENT_KEY
- pixel_col  out  7  sprite column of pixel_data
- pixel_last  out  1  final pixel of the run

Behaviour:
- Interface: one clock Clk; Reset is synchronous, active-high.
- Reset: all outputs are 0 and the FSM enters IDLE. Reset mid-run discards all in-flight pixels, with no done pulse.
- FSM states: IDLE, FETCH, DRAIN.
- In IDLE, start latches sprite_sel, row, col_start and run_len.
- Clipping and count:
  - W and H are the dimensions of the selected sprite.
  - n = 0 if row >= H or col_start >= W; otherwise n = min(run_len, W - col_start).
- n = 0: done pulses in the next cycle, busy stays low, no ROM access.
- n > 0: busy is high from the cycle after start until the cycle of the last pixel handshake; state goes to FETCH.
- FETCH:
  - rom_addr = row*W + col. Use a constant-width mux or shift-add; no generic multiplier.
  - col advances from col_start by 1 per issued address, for n addresses.
  - Go to DRAIN after the last address issues.
- DRAIN: wait until every issued pixel is handshaken, then return to IDLE. done pulses in the cycle after the last handshake, with busy low.
- Latency: start high in cycle 0 -> rom_addr = A0 in cycle 1 -> ROM data in cycle 2 -> registered output with pixel_valid in cycle 3.
- Throughput: 1 pixel per cycle while pixel_ready = 1.
- Backpressure:
  - A pixel transfers when pixel_valid && pixel_ready.
  - While pixel_valid && !pixel_ready, pixel_data, pixel_col, pixel_last and pixel_transparent hold stable.
  - The address stage stalls so no ROM word is lost or duplicated; a 2-entry skid buffer is required.
  - pixel_ready may change in any cycle.
- Data path:
  - pixel_data = ROM data selected by the latched sel.
  - pixel_transparent is computed on the same data.
  - pixel_last = 1 only on the pixel with pixel_col = col_start + n - 1.
- start while busy, or during the done cycle, is ignored with no side effects.
- rom_sel holds the latched sel from start acceptance through done. rom_addr holds its last value when idle.

Test Plan:
- Brick, row 3, col 0, len 16, ready = 1 -> rom_addr 48..63 in cycles 1..16; pixel_valid in cycles 3..18 carrying mem[48..63], pixel_col 0..15; pixel_last in cycle 18; done in cycle 19.
- bhill, row 34, col 70, len 20 -> clipped to 10 pixels; addresses 2790..2799; pixel_last at pixel_col 79; done one cycle after the 10th handshake.
- bcloud, row 32, len 5 -> done in cycle 1, no pixel_valid, busy never high. Repeat with question, row 0, len 0 -> same result.
- Question, row 15, col 2, len 12, with pixel_ready low for 5 cycles after the 3rd pixel and then toggling -> accepted pixels are exactly mem[242..253] in order, with no drop or duplicate; outputs stable during the stall.
- Start pulsed at cycle 5 of an active run -> ignored. Reset at cycle 6 -> all outputs 0 in cycle 7, no done. A fresh start in cycle 8 completes normally.
- Brick row where mem word = 24'hFF00FF -> pixel_transparent = 1 on exactly that pixel and 0 on every other pixel.
